// File: rtl/add16u_err_monitor.sv
// add16u_err_monitor
// Streaming error-metric collector for 16-bit unsigned approximate adders.
// Each accepted sample (a, b, o_approx) is compared against the exact sum
// a+b. Over a window of 2^LOG2_SAMPLES accepted samples the block collects:
//   wce     - worst-case absolute error
//   err_sum - summed absolute error
//   err_cnt - number of erroneous samples
//   sq_sum  - summed squared error (only when ERR_MSE_EN is defined;
//             otherwise the port is tied to zero and no multiplier exists)
// Optional feature macro: ERR_MSE_EN
// Pipeline: S1 input register, S2 exact sum / abs error, S3 accumulate.
module add16u_err_monitor #(
   parameter int LOG2_SAMPLES = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [15:0]                 a,
   input  logic [15:0]                 b,
   input  logic [16:0]                 o_approx,
   output logic                        busy,
   output logic                        done,
   output logic [16:0]                 wce,
   output logic [17+LOG2_SAMPLES-1:0]  err_sum,
   output logic [LOG2_SAMPLES:0]       err_cnt,
   output logic [34+LOG2_SAMPLES-1:0]  sq_sum
);

   localparam int DATA_W = 16;
   localparam int ERR_W  = DATA_W + 1;
   localparam int SUM_W  = ERR_W + LOG2_SAMPLES;
   localparam int CNT_W  = LOG2_SAMPLES + 1;
   localparam int SQ_W   = 2 * ERR_W + LOG2_SAMPLES;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Absolute difference of two 17-bit unsigned values, computed on an
   // 18-bit signed difference so that the subtraction can never wrap.
   function automatic logic [ERR_W-1:0] abs_err(input logic [ERR_W-1:0] x,
                                                input logic [ERR_W-1:0] y);
      logic signed [ERR_W:0] diff;
      diff = $signed({1'b0, x}) - $signed({1'b0, y});
      if (diff < 0) begin
         abs_err = ERR_W'(-diff);
      end else begin
         abs_err = ERR_W'(diff);
      end
   endfunction

   state_t                    state_q;
   logic                      busy_q;
   logic                      done_q;
   logic [LOG2_SAMPLES-1:0]   smp_cnt_q;

   logic                      accept;
   logic                      clr;
   logic                      last_accept;

   // S1 registers
   logic [DATA_W-1:0]         a_p1_q;
   logic [DATA_W-1:0]         b_p1_q;
   logic [ERR_W-1:0]          o_p1_q;
   logic                      vld_p1_q;

   // S2 registers and combinational inputs
   logic [ERR_W-1:0]          exact_p1;
   logic [ERR_W-1:0]          err_p1;
   logic [ERR_W-1:0]          err_p2_q;
   logic                      flag_p2_q;
   logic                      vld_p2_q;

   // S3 accumulators
   logic [ERR_W-1:0]          wce_q;
   logic [SUM_W-1:0]          err_sum_q;
   logic [CNT_W-1:0]          err_cnt_q;

   assign in_ready    = (state_q == ST_RUN);
   assign accept      = in_valid & in_ready;
   assign last_accept = accept & (smp_cnt_q == {LOG2_SAMPLES{1'b1}});
   assign clr         = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

   assign busy    = busy_q;
   assign done    = done_q;
   assign wce     = wce_q;
   assign err_sum = err_sum_q;
   assign err_cnt = err_cnt_q;

   // Window control FSM with registered busy/done and the accepted-sample counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         smp_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q   <= ST_RUN;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  smp_cnt_q <= '0;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  smp_cnt_q <= smp_cnt_q + LOG2_SAMPLES'(1);
               end
               if (last_accept) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Wait until the final sample has left both pipeline stages.
               if (!vld_p1_q && !vld_p2_q) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // ---- S1: capture accepted sample ----
   // Valid bit for S1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q <= 1'b0;
      end else begin
         vld_p1_q <= accept;
      end
   end

   // S1 data registers load only on an accepted sample
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p1_q <= a;
         b_p1_q <= b;
         o_p1_q <= o_approx;
      end
   end

   // ---- S2: exact sum and absolute error ----
   assign exact_p1 = {1'b0, a_p1_q} + {1'b0, b_p1_q};
   assign err_p1   = abs_err(exact_p1, o_p1_q);

   // Valid bit for S2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2_q <= 1'b0;
      end else begin
         vld_p2_q <= vld_p1_q;
      end
   end

   // S2 data registers: error magnitude and nonzero flag
   always_ff @(posedge clk) begin
      if (vld_p1_q) begin
         err_p2_q  <= err_p1;
         flag_p2_q <= (err_p1 != '0);
      end
   end

   // ---- S3: accumulate metrics ----
   // Worst-case, summed error and error count; cleared by an honoured start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wce_q     <= '0;
         err_sum_q <= '0;
         err_cnt_q <= '0;
      end else if (clr) begin
         wce_q     <= '0;
         err_sum_q <= '0;
         err_cnt_q <= '0;
      end else if (vld_p2_q) begin
         if (err_p2_q > wce_q) begin
            wce_q <= err_p2_q;
         end
         err_sum_q <= err_sum_q + SUM_W'(err_p2_q);
         err_cnt_q <= err_cnt_q + CNT_W'(flag_p2_q);
      end
   end

`ifdef ERR_MSE_EN
   logic [2*ERR_W-1:0] sq_term_p2;
   logic [SQ_W-1:0]    sq_sum_q;

   assign sq_term_p2 = {{ERR_W{1'b0}}, err_p2_q} * {{ERR_W{1'b0}}, err_p2_q};
   assign sq_sum     = sq_sum_q;

   // Summed squared error, same clear/update rules as the other metrics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_sum_q <= '0;
      end else if (clr) begin
         sq_sum_q <= '0;
      end else if (vld_p2_q) begin
         sq_sum_q <= sq_sum_q + SQ_W'(sq_term_p2);
      end
   end
`else
   assign sq_sum = '0;
`endif

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Scoreboard bench for add16u_err_monitor with a 4-sample window.
// Expected window metrics are queued when a window is launched; a monitor
// process pops and compares them when done rises, and also checks done
// latency and the number of handshaken samples in the window.
module tb_add16u_err_monitor;

   localparam int L = 2;
`ifdef ERR_MSE_EN
   localparam bit MSE = 1'b1;
`else
   localparam bit MSE = 1'b0;
`endif

   typedef struct {
      logic [16:0] wce;
      logic [18:0] sum;
      logic [2:0]  cnt;
      logic [35:0] sq;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [16:0] o_approx = '0;
   logic        in_ready, busy, done;
   logic [16:0] wce;
   logic [18:0] err_sum;
   logic [2:0]  err_cnt;
   logic [35:0] sq_sum;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;

   logic [15:0] va[4];
   logic [15:0] vb[4];
   logic [16:0] vo[4];

   add16u_err_monitor #(.LOG2_SAMPLES(L)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .a(a), .b(b), .o_approx(o_approx),
      .busy(busy), .done(done), .wce(wce), .err_sum(err_sum),
      .err_cnt(err_cnt), .sq_sum(sq_sum)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   function automatic logic [35:0] sqx(input logic [35:0] v);
      return MSE ? v : 36'd0;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   // Monitor: track handshakes and compare metrics when done rises
   initial begin : monitor
      int   acc_n;
      int   last_acc;
      logic done_prev;
      exp_t e;
      acc_n = 0;
      last_acc = 0;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc_n = 0;
            done_prev = 1'b0;
         end else begin
            if (start && !busy) acc_n = 0;
            if (in_valid && in_ready) begin
               acc_n++;
               last_acc = cyc + 1;
            end
            if (done && !done_prev) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_empty: done rose with no queued expectation");
               end else begin
                  e = sb.pop_front();
                  check("wce", 64'(wce), 64'(e.wce));
                  check("err_sum", 64'(err_sum), 64'(e.sum));
                  check("err_cnt", 64'(err_cnt), 64'(e.cnt));
                  check("sq_sum", 64'(sq_sum), 64'(e.sq));
                  check("done_latency", 64'(cyc), 64'(last_acc + 3));
                  check("accept_count", 64'(acc_n), 64'd4);
               end
            end
            done_prev = done;
         end
      end
   end

   task automatic load(input int i, input logic [15:0] ai, input logic [15:0] bi,
                       input logic [16:0] oi);
      va[i] = ai;
      vb[i] = bi;
      vo[i] = oi;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [15:0] ai, input logic [15:0] bi, input logic [16:0] oi);
      a = ai;
      b = bi;
      o_approx = oi;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = $urandom_range(16'hFFFF, 0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: done still 0 after %0d cycles", n);
      end
      tick();
   endtask

   task automatic run_window(input bit gaps, input bit mid_start, input exp_t e);
      sb.push_back(e);
      do_start();
      check("start_done_clr", 64'(done), 64'd0);
      check("start_busy", 64'(busy), 64'd1);
      check("start_wce_clr", 64'(wce), 64'd0);
      check("start_sum_clr", 64'(err_sum), 64'd0);
      check("start_cnt_clr", 64'(err_cnt), 64'd0);
      for (int i = 0; i < 4; i++) begin
         send(va[i], vb[i], vo[i]);
         if (gaps && i < 3) tick();
         if (mid_start && i == 1) do_start();
      end
      check("in_ready_drop", 64'(in_ready), 64'd0);
      check("busy_drain", 64'(busy), 64'd1);
      wait_done();
   endtask

   initial begin : stim
      // Reset with active-looking inputs
      start = 1'b1;
      in_valid = 1'b1;
      a = 16'hFFFF;
      b = 16'hFFFF;
      o_approx = 17'd0;
      #23;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_wce", 64'(wce), 64'd0);
      check("rst_err_sum", 64'(err_sum), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_sq_sum", 64'(sq_sum), 64'd0);
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      // Exact adder
      for (int i = 0; i < 4; i++) load(i, 16'd100, 16'd200, 17'd300);
      run_window(1'b0, 1'b0, '{wce: 17'd0, sum: 19'd0, cnt: 3'd0, sq: 36'd0});

      // Mixed errors 132, 4, 0, 64 (window started from DONE)
      load(0, 16'h8000, 16'h0084, 17'h08000);
      load(1, 16'd10, 16'd10, 17'd24);
      load(2, 16'd5, 16'd7, 17'd12);
      load(3, 16'hFFFF, 16'h0001, 17'h10040);
      run_window(1'b0, 1'b0, '{wce: 17'd132, sum: 19'd200, cnt: 3'd3, sq: sqx(36'd21536)});

      // Extremes
      for (int i = 0; i < 4; i++) load(i, 16'hFFFF, 16'hFFFF, 17'd0);
      run_window(1'b0, 1'b0, '{wce: 17'h1FFFE, sum: 19'h7FFF8, cnt: 3'd4,
                               sq: sqx(36'hF_FFE0_0010)});

      // in_valid gaps plus a start pulse in RUN that must be ignored
      for (int i = 0; i < 4; i++) load(i, 16'd1, 16'd1, 17'd0);
      run_window(1'b1, 1'b1, '{wce: 17'd2, sum: 19'd8, cnt: 3'd4, sq: sqx(36'd16)});

      // Mid-run reset after two accepts
      do_start();
      send(16'hFFFF, 16'hFFFF, 17'd0);
      send(16'hFFFF, 16'hFFFF, 17'd0);
      tick();
      tick();
      check("pre_rst_err_sum", 64'(err_sum), 64'h3FFFC);
      check("pre_rst_err_cnt", 64'(err_cnt), 64'd2);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_wce", 64'(wce), 64'd0);
      check("midrst_err_sum", 64'(err_sum), 64'd0);
      check("midrst_err_cnt", 64'(err_cnt), 64'd0);
      check("midrst_sq_sum", 64'(sq_sum), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_idle_ready", 64'(in_ready), 64'd0);
      check("post_rst_idle_busy", 64'(busy), 64'd0);

      // Fresh full window after the reset
      load(0, 16'h8000, 16'h0084, 17'h08000);
      load(1, 16'd10, 16'd10, 17'd24);
      load(2, 16'd5, 16'd7, 17'd12);
      load(3, 16'hFFFF, 16'h0001, 17'h10040);
      run_window(1'b0, 1'b0, '{wce: 17'd132, sum: 19'd200, cnt: 3'd3, sq: sqx(36'd21536)});

      tick();
      tick();
      check("done_hold", 64'(done), 64'd1);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
